// File: rtl/seq_neuron_mac.sv
// seq_neuron_mac: time-multiplexed float32 neuron.
// A single multiplier and adder accumulate N_INPUTS activation*weight products
// one beat per cycle. The bias is then added, linear or ReLU activation is
// applied, and the result is held on a valid/ready output.
// Arithmetic is IEEE-754 single with round-to-nearest-even. Subnormal operands
// and results are flushed to signed zero. NaN and Inf propagate.
module seq_neuron_mac #(
  parameter int N_INPUTS     = 30,
  parameter int IDX_W        = $clog2(N_INPUTS),
  parameter bit RELU_DEFAULT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w_we,
  input  logic [IDX_W-1:0] w_addr,
  input  logic [31:0]      w_data,
  input  logic             b_we,
  input  logic [31:0]      b_data,
  input  logic             mode_we,
  input  logic             mode_relu,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             cfg_err
);

  localparam int AW = $clog2(N_INPUTS);

  typedef enum logic [1:0] {IDLE, ACCUM, BIAS, OUT} state_t;

  // Packing trick: the hidden bit in r carries into the exponent field, so a
  // rounding overflow bumps the exponent for free.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    logic [23:0] m;
    logic        g, st;
    logic [24:0] r;
    int          e, t;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'hFF && a[22:0] != '0) return a;
    if (b[30:23] == 8'hFF && b[22:0] != '0) return b;
    if ((a[30:23] == 8'hFF && b[30:23] == 8'h00) ||
        (b[30:23] == 8'hFF && a[30:23] == 8'h00)) return 32'h7FC0_0000;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {s, 8'hFF, 23'h0};
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'h0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[47:24]; g = p[23]; st = |p[22:0]; e = e + 1;
    end else begin
      m = p[46:23]; g = p[22]; st = |p[21:0];
    end
    r = 25'({1'b0, m}) + 25'(g & (st | m[0]));
    t = ((e - 1) <<< 23) + int'(r);
    if (t >= (255 <<< 23)) return {s, 8'hFF, 23'h0};
    if (t < (1 <<< 23)) return {s, 31'h0};
    return {s, t[30:0]};
  endfunction

  // Larger magnitude first, smaller aligned with guard/round/sticky bits.
  // Exact cancellation yields +0.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [49:0] bs;
    logic [26:0] ax, by, n;
    logic [27:0] sum;
    logic [24:0] r;
    int          d, e, lz, t;
    if (a[30:23] == 8'hFF && a[22:0] != '0) return a;
    if (b[30:23] == 8'hFF && b[22:0] != '0) return b;
    if (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31]) return 32'h7FC0_0000;
    if (a[30:23] == 8'hFF) return a;
    if (b[30:23] == 8'hFF) return b;
    if (a[30:23] == 8'h00 && b[30:23] == 8'h00) return {a[31] & b[31], 31'h0};
    if (a[30:23] == 8'h00) return b;
    if (b[30:23] == 8'h00) return a;
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else begin x = b; y = a; end
    d  = int'(x[30:23]) - int'(y[30:23]);
    ax = {1'b1, x[22:0], 3'b000};
    if (d > 49) begin
      bs = '0;
      by = 27'd1;
    end else begin
      bs = {1'b1, y[22:0], 26'h0} >> d;
      by = {bs[49:24], |bs[23:0]};
    end
    sum = (x[31] ^ y[31]) ? ({1'b0, ax} - {1'b0, by}) : ({1'b0, ax} + {1'b0, by});
    if (sum == '0) return 32'h0;
    e = int'(x[30:23]);
    if (sum[27]) begin
      n = {sum[27:2], sum[1] | sum[0]};
      e = e + 1;
    end else begin
      n  = sum[26:0];
      lz = 0;
      for (int unsigned i = 0; i < 27; i++) begin
        if (!n[26]) begin
          n  = n << 1;
          lz = lz + 1;
        end
      end
      e = e - lz;
    end
    r = 25'({1'b0, n[26:3]}) + 25'(n[2] & ((|n[1:0]) | n[3]));
    t = ((e - 1) <<< 23) + int'(r);
    if (t >= (255 <<< 23)) return {x[31], 8'hFF, 23'h0};
    if (t < (1 <<< 23)) return {x[31], 31'h0};
    return {x[31], t[30:0]};
  endfunction

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic        relu_q, relu_d;
  logic        relu_act_q, relu_act_d;
  logic        cfg_err_q, cfg_err_d;
  logic [31:0] w_q [N_INPUTS];
  logic [31:0] b_q;

  logic        accept, in_range, w_ok, b_ok;
  logic [31:0] prod, add_a, add_b, sum;

  // The multiplier and adder are shared. The adder takes a zero seed on the
  // first beat and the bias in BIAS.
  assign prod  = fmul(in_data, w_q[AW'(cnt_q)]);
  assign add_a = (state_q == IDLE) ? '0 : acc_q;
  assign add_b = (state_q == BIAS) ? b_q : prod;
  assign sum   = fadd(add_a, add_b);

  assign busy      = (state_q != IDLE);
  assign in_ready  = rst_n && (state_q == IDLE || state_q == ACCUM);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == OUT);
  assign out_data  = (state_q != OUT) ? '0 : ((relu_act_q && acc_q[31]) ? '0 : acc_q);
  assign cfg_err   = cfg_err_q;
  assign in_range  = 32'(w_addr) < N_INPUTS;

  // Config writes land only while idle. Rejected writes flag an error next cycle.
  always_comb begin
    w_ok      = w_we && !busy && in_range;
    b_ok      = b_we && !busy;
    relu_d    = (mode_we && !busy) ? mode_relu : relu_q;
    cfg_err_d = (w_we && (busy || !in_range)) || ((b_we || mode_we) && busy);
  end

  // Weight and bias register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '{default: '0};
      b_q <= '0;
    end else begin
      if (w_ok) w_q[AW'(w_addr)] <= w_data;
      if (b_ok) b_q <= b_data;
    end
  end

  // Evaluation sequencing: next state, accumulator and beat counter.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    relu_act_d = relu_act_q;
    case (state_q)
      IDLE: if (accept) begin
        acc_d      = sum;
        cnt_d      = IDX_W'(1);
        relu_act_d = relu_q;
        state_d    = ACCUM;
      end
      ACCUM: if (accept) begin
        acc_d = sum;
        if (cnt_q == IDX_W'(N_INPUTS - 1)) state_d = BIAS;
        else cnt_d = cnt_q + IDX_W'(1);
      end
      BIAS: begin
        acc_d   = sum;
        state_d = OUT;
      end
      OUT: if (out_ready) begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      relu_q     <= RELU_DEFAULT;
      relu_act_q <= RELU_DEFAULT;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      relu_q     <= relu_d;
      relu_act_q <= relu_act_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_seq_neuron_mac.sv
// Bench for seq_neuron_mac: a real-arithmetic neuron model predicts every result.
module tb_seq_neuron_mac;
  localparam logic [31:0] ONE = 32'h3F80_0000, HALF = 32'h3F00_0000;
  localparam logic [31:0] TWO = 32'h4000_0000, NEG1 = 32'hBF80_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        w_we = 0, b_we = 0, mode_we = 0, mode_relu = 0, in_valid = 0, out_ready = 0;
  logic [2:0]  w_addr = '0;
  logic [31:0] w_data = '0, b_data = '0, in_data = '0, out_data;
  logic        in_ready, out_valid, busy, cfg_err;

  logic        s_w_we = 0, s_b_we = 0, s_mode_we = 0, s_mode_relu = 0, s_in_valid = 0, s_out_ready = 0;
  logic [4:0]  s_w_addr = '0;
  logic [31:0] s_w_data = '0, s_b_data = '0, s_in_data = '0, s_out_data;
  logic        s_in_ready, s_out_valid, s_busy, s_cfg_err;

  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] xin[30], mw[30];
  logic [31:0] mb = '0;
  bit          mrelu = 1'b1;

  seq_neuron_mac #(.N_INPUTS(4), .IDX_W(3), .RELU_DEFAULT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .b_we(b_we), .b_data(b_data), .mode_we(mode_we), .mode_relu(mode_relu),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .cfg_err(cfg_err));

  seq_neuron_mac #(.N_INPUTS(30), .IDX_W(5), .RELU_DEFAULT(1'b1)) dut30 (
    .clk(clk), .rst_n(rst_n), .w_we(s_w_we), .w_addr(s_w_addr), .w_data(s_w_data),
    .b_we(s_b_we), .b_data(s_b_data), .mode_we(s_mode_we), .mode_relu(s_mode_relu),
    .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(s_out_ready),
    .busy(s_busy), .cfg_err(s_cfg_err));

  // float32 <-> real; subnormals flush to zero, inputs kept finite.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'h00) d = {f[31], 63'h0};
    else d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [24:0] m;
    int e;
    d = $realtobits(r);
    if (d[62:52] == 11'h0) return {d[63], 31'h0};
    e = int'(d[62:52]) - 1023 + 127;
    m = {2'b01, d[51:29]};
    if (d[28] && ((|d[27:0]) || m[0])) m = m + 25'd1;
    if (m[24]) begin e = e + 1; m = m >> 1; end
    if (e >= 255) return {d[63], 8'hFF, 23'h0};
    if (e <= 0) return {d[63], 31'h0};
    return {d[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] neuron(input int n, input logic [31:0] x[30],
                                         input logic [31:0] w[30], input logic [31:0] b,
                                         input bit relu);
    logic [31:0] acc, p;
    acc = 32'h0;
    for (int i = 0; i < n; i++) begin
      p   = r2f(f2r(x[i]) * f2r(w[i]));
      acc = r2f(f2r(acc) + f2r(p));
    end
    acc = r2f(f2r(acc) + f2r(b));
    return (relu && acc[31]) ? 32'h0 : acc;
  endfunction

  function automatic logic [31:0] rnd_f();
    if ($urandom_range(0, 7) == 0) return {1'($urandom_range(0, 1)), 31'h0};
    return {1'($urandom_range(0, 1)), 8'(120 + $urandom_range(0, 14)), 23'($urandom)};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, expv, $time);
    end
  endtask

  // Every cycle the result is valid it must match the oldest predicted result.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) chk("unexpected_out_valid", 32'(out_valid), 32'h0);
      else begin
        chk("out_data", out_data, exp_q[0]);
        chk("in_ready_in_out", 32'(in_ready), 32'h0);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic cfg(input bit ww, input logic [2:0] a, input logic [31:0] wd,
                     input bit bw, input logic [31:0] bd, input bit mwe, input bit m);
    w_we = ww; w_addr = a; w_data = wd; b_we = bw; b_data = bd; mode_we = mwe; mode_relu = m;
    @(posedge clk); #1;
    w_we = 0; b_we = 0; mode_we = 0;
    chk("cfg_err_idle", 32'(cfg_err), 32'(ww && a >= 3'd4));
    if (ww && a < 3'd4) mw[a] = wd;
    if (bw) mb = bd;
    if (mwe) mrelu = m;
  endtask

  task automatic run4(input bit bub, input int hold, input int inj);
    int cyc;
    exp_q.push_back(neuron(4, xin, mw, mb, mrelu));
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_data = xin[i];
      if (i == inj) begin w_we = 1; w_addr = 3'd1; w_data = 32'h4040_0000; end
      @(negedge clk);
      chk("in_ready_beat", 32'(in_ready), 32'h1);
      @(posedge clk); #1;
      in_valid = 0; in_data = $urandom;
      if (i == inj) begin w_we = 0; chk("cfg_err_busy", 32'(cfg_err), 32'h1); end
      if (bub && i < 3) begin @(posedge clk); #1; end
    end
    cyc = 0;
    while (!out_valid && cyc < 20) begin @(negedge clk); cyc++; end
    chk("latency", 32'(cyc), 32'd2);
    repeat (hold) @(negedge clk);
    @(posedge clk); #1; out_ready = 1;
    @(posedge clk); #1; out_ready = 0;
    chk("busy_after_hs", 32'(busy), 32'h0);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic load_basic();
    for (int i = 0; i < 4; i++) cfg(1, 3'(i), ONE, 0, '0, 0, 0);
    cfg(0, 3'd0, '0, 1, HALF, 1, 1);
    xin[0] = ONE; xin[1] = TWO; xin[2] = HALF; xin[3] = HALF;
  endtask

  task automatic test30();
    logic [31:0] w30[30], x30[30], e30;
    int cyc;
    for (int i = 0; i < 30; i++) begin w30[i] = ONE; x30[i] = ONE; end
    e30 = neuron(30, x30, w30, 32'h0, 1'b1);
    chk("pin_n30", e30, 32'h41F0_0000);
    for (int i = 0; i < 30; i++) begin
      s_w_we = 1; s_w_addr = 5'(i); s_w_data = ONE;
      @(posedge clk); #1;
    end
    s_w_addr = 5'd30; s_w_data = TWO; s_b_we = 1; s_b_data = 32'h0;
    @(posedge clk); #1;
    s_w_we = 0; s_b_we = 0;
    chk("cfg_err_addr30", 32'(s_cfg_err), 32'h1);
    s_in_valid = 1; s_in_data = ONE;
    repeat (30) begin @(posedge clk); #1; end
    s_in_valid = 0;
    cyc = 0;
    while (!s_out_valid && cyc < 20) begin @(negedge clk); cyc++; end
    chk("latency30", 32'(cyc), 32'd2);
    chk("out_data30", s_out_data, e30);
    @(posedge clk); #1; s_out_ready = 1;
    @(posedge clk); #1; s_out_ready = 0;
    chk("busy30_after_hs", 32'(s_busy), 32'h0);
  endtask

  initial begin
    logic [31:0] tw[30], tx[30];
    for (int i = 0; i < 30; i++) begin xin[i] = '0; mw[i] = '0; tw[i] = '0; tx[i] = '0; end
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cfg_err", 32'(cfg_err), 32'h0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("idle_in_ready", 32'(in_ready), 32'h1);

    // Hand-computed results pin the model.
    for (int i = 0; i < 4; i++) tw[i] = ONE;
    tx[0] = ONE; tx[1] = TWO; tx[2] = HALF; tx[3] = HALF;
    chk("pin_basic", neuron(4, tx, tw, HALF, 1'b1), 32'h4090_0000);
    for (int i = 0; i < 4; i++) begin tw[i] = NEG1; tx[i] = ONE; end
    chk("pin_linear", neuron(4, tx, tw, HALF, 1'b0), 32'hC060_0000);
    chk("pin_relu", neuron(4, tx, tw, HALF, 1'b1), 32'h0000_0000);

    load_basic();
    run4(0, 0, -1);
    for (int i = 0; i < 4; i++) cfg(1, 3'(i), NEG1, 0, '0, 0, 0);
    for (int i = 0; i < 4; i++) xin[i] = ONE;
    cfg(0, 3'd0, '0, 0, '0, 1, 0);
    run4(0, 0, -1);
    cfg(0, 3'd0, '0, 0, '0, 1, 1);
    run4(0, 0, -1);

    load_basic();
    run4(1, 5, -1);
    run4(0, 0, -1);
    run4(0, 1, 2);
    cfg(1, 3'd4, TWO, 0, '0, 0, 0);
    run4(0, 0, -1);

    // Reset mid-ACCUM after two beats; weights and bias are lost.
    in_valid = 1; in_data = xin[0];
    @(posedge clk); #1; in_data = xin[1];
    @(posedge clk); #1; in_valid = 0;
    chk("busy_mid", 32'(busy), 32'h1);
    rst_n = 0; #1;
    chk("midrst_in_ready", 32'(in_ready), 32'h0);
    chk("midrst_out_data", out_data, 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    exp_q.delete();
    for (int i = 0; i < 4; i++) mw[i] = '0;
    mb = '0; mrelu = 1'b1;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    load_basic();
    run4(0, 0, -1);

    for (int k = 0; k < 50; k++) begin
      cfg(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rnd_f(),
          1'($urandom_range(0, 1)), rnd_f(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 4; i++) xin[i] = rnd_f();
      run4(1'($urandom_range(0, 1)), $urandom_range(0, 3),
           ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : -1);
    end

    test30();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_neuron_mac.md
Name: seq_neuron_mac

Overview:
- Time-multiplexed, parametrised float32 neuron that replaces the fully unrolled per-node multiplier/adder trees.
- Holds N_INPUTS weights and one bias in a writable register file.
- Accepts activations as a valid/ready stream, one per cycle, into a single float_mult + float_adder accumulator.
- Adds the bias, applies a run-time selectable activation (linear or ReLU) and presents the result on a valid/ready output.

Parameters:
- N_INPUTS, 30, activations (and weights) per neuron evaluation; legal range 2..1024.
- IDX_W, $clog2(N_INPUTS), width of weight address and beat counter.
- RELU_DEFAULT, 1, value of the activation-mode register after reset (1 = ReLU, 0 = linear).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- w_we  in  1  weight write strobe.
- w_addr  in  IDX_W  weight index.
- w_data  in  32  IEEE-754 single weight.
- b_we  in  1  bias write strobe.
- b_data  in  32  IEEE-754 single bias.
- mode_we  in  1  activation-mode write strobe.
- mode_relu  in  1  new activation mode.
- in_valid  in  1  activation beat valid.
- in_data  in  32  activation, float32.
- in_ready  out  1  block accepts activation this cycle.
- out_valid  out  1  result valid.
- out_data  out  32  activated result, float32.
- out_ready  in  1  consumer accepts result.
- busy  out  1  evaluation in progress (state != IDLE).
- cfg_err  out  1  one-cycle pulse: config write rejected.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, acc=32'h0, cnt=0, relu=RELU_DEFAULT.
  - in_ready=0, out_valid=0, out_data=32'h0, busy=0, cfg_err=0.
  - Weight/bias registers reset to 32'h0.
- FSM states: IDLE, ACCUM, BIAS, OUT.
- IDLE:
  - in_ready=1.
  - Config writes (w_we, b_we, mode_we) are accepted here only.
  - w_addr >= N_INPUTS is ignored and pulses cfg_err next cycle.
  - First accepted beat (in_valid&in_ready): acc <= 0 + in_data*W[0], cnt <= 1, state <= ACCUM.
  - relu_active <= relu, latched for the whole evaluation.
- ACCUM:
  - in_ready=1.
  - Each accepted beat: acc <= acc + in_data*W[cnt], cnt <= cnt+1.
  - in_valid=0 bubbles stall without changing acc or cnt.
  - The beat with cnt==N_INPUTS-1 moves to BIAS.
- BIAS:
  - in_ready=0, one cycle: acc <= acc + B.
  - Moves to OUT.
- OUT:
  - in_ready=0, out_valid=1.
  - out_data = relu_active && acc[31] ? 32'h0 : acc. Negative zero maps to +0 under ReLU.
  - out_data stable while out_valid&!out_ready.
  - On out_ready: out_valid <= 0, acc <= 0, cnt <= 0, state <= IDLE.
- Timing and throughput:
  - Latency from the last accepted beat to out_valid is 2 cycles.
  - Throughput is one evaluation per N_INPUTS+2 cycles plus the output handshake.
  - The next evaluation's first beat is accepted no earlier than the cycle after the output handshake, because in_ready is deasserted in OUT.
- Config writes while busy=1:
  - Ignored, and cfg_err pulses the following cycle.
  - This guarantees that weights, bias and mode are constant during an evaluation.
  - Simultaneous w_we, b_we and mode_we in IDLE are all applied.
- Arithmetic:
  - The product and sum use existing float_mult/float_adder, combinational.
  - One multiply and one add per cycle, no other rounding or saturation.
  - NaN/Inf pass through the adder unchanged. ReLU checks only bit 31.
- Reset mid-evaluation: all state cleared immediately and the partial sum is discarded. Weights and bias are cleared as well, so software must reload them.
- cnt wrap: never exceeds N_INPUTS-1, because the transition to BIAS occurs on the final beat.

Test Plan:
- Basic dot product. N_INPUTS=4, W={3F800000 x4}, B=3F000000, relu=1, inputs 3F800000,40000000,3F000000,3F000000 back-to-back -> out_data=40900000 (4.5), out_valid 2 cycles after 4th beat.
- Linear vs ReLU. W={BF800000 x4}, B=3F000000, inputs 3F800000 x4.
  - relu=0 -> out_data=C0600000 (-3.5).
  - relu=1 -> out_data=00000000.
- Bubbles and backpressure. Same as first test with in_valid toggling 1,0,1,0,..., and out_ready held 0 for 5 cycles -> result 40900000.
  - out_data stable during the hold, in_ready=0 throughout OUT.
  - Next evaluation starts correctly after the handshake.
- Config protection.
  - w_we to addr 1 during ACCUM -> cfg_err pulse, result unchanged.
  - w_we with w_addr=4 in IDLE (N_INPUTS=4) -> cfg_err, no register changes.
- Async reset mid-ACCUM after 2 beats -> outputs zero immediately.
  - Reload W/B and run first test -> 40900000 (no stale partial sum).
- Default instance N_INPUTS=30: all W=3F800000, B=0, inputs all 3F800000 -> out_data=41F00000 (30.0).
